// File: rtl/uart_axil_pkg.sv
// rtl/uart_axil_pkg.sv - shared constants for the UART to AXI-Lite debug bridge
package uart_axil_pkg;

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_READ      = 8'h02;
  localparam logic [7:0] RESP_OK_BASE = 8'hA0;
  localparam logic [7:0] RESP_BADCMD  = 8'hEE;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_AW_W = 3'd3;
  localparam logic [2:0] ST_B    = 3'd4;
  localparam logic [2:0] ST_AR   = 3'd5;
  localparam logic [2:0] ST_R    = 3'd6;
  localparam logic [2:0] ST_RESP = 3'd7;

  // Status byte reported to the host: fixed upper nibble, AXI response code below.
  function automatic logic [7:0] resp_status(input logic [1:0] resp);
    return RESP_OK_BASE | {6'b0, resp};
  endfunction

endpackage

// File: rtl/uart_axil_resp_ser.sv
// rtl/uart_axil_resp_ser.sv - up to 5-byte response serializer feeding the UART tx stream
module uart_axil_resp_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [39:0] data_i,
  input  logic [2:0]  len_i,
  output logic [7:0]  tdata_o,
  output logic        tvalid_o,
  input  logic        tready_i,
  output logic        done_o
);

  logic [39:0] sh_q, sh_d;
  logic [2:0]  len_q, len_d;

  // Front byte is always the top of the shift register, so tdata holds until accepted.
  assign tdata_o  = sh_q[39:32];
  assign tvalid_o = (len_q != 3'd0);

  // Load a new response or shift one byte out per accepted beat.
  always_comb begin
    sh_d   = sh_q;
    len_d  = len_q;
    done_o = 1'b0;
    if (load_i) begin
      sh_d  = data_i;
      len_d = len_i;
    end else if (tvalid_o && tready_i) begin
      sh_d   = {sh_q[31:0], 8'h00};
      len_d  = len_q - 3'd1;
      done_o = (len_q == 3'd1);
    end
  end

  // Shift register and remaining-length counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      len_q <= '0;
    end else begin
      sh_q  <= sh_d;
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/uart_axil_master.sv
// rtl/uart_axil_master.sv - UART byte-stream command decoder issuing single-beat AXI-Lite accesses
module uart_axil_master
  import uart_axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [31:0]           m_axil_wdata,
  output logic [3:0]            m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [31:0]           m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic                  busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [2:0]            state_q, state_d;
  logic                  is_write_q, is_write_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  s_tready_q, s_tready_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;

  logic                  byte_acc;
  logic                  ser_load;
  logic [39:0]           ser_data;
  logic [2:0]            ser_len;
  logic                  ser_done;

  assign byte_acc       = s_axis_tvalid && s_tready_q;
  assign s_axis_tready  = s_tready_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_wdata   = data_q;
  assign m_axil_wstrb   = 4'hF;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_rready  = rready_q;
  assign busy           = (state_q != ST_IDLE);

  uart_axil_resp_ser u_resp_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ser_load),
    .data_i   (ser_data),
    .len_i    (ser_len),
    .tdata_o  (m_axis_tdata),
    .tvalid_o (m_axis_tvalid),
    .tready_i (m_axis_tready),
    .done_o   (ser_done)
  );

  // Frame decode, AXI sequencing and inter-byte timeout.
  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = '0;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    ser_load   = 1'b0;
    ser_data   = '0;
    ser_len    = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (byte_acc) begin
          if (s_axis_tdata == OP_WRITE || s_axis_tdata == OP_READ) begin
            is_write_d = (s_axis_tdata == OP_WRITE);
            byte_cnt_d = 2'd0;
            state_d    = ST_ADDR;
          end else begin
            ser_load = 1'b1;
            ser_data = {RESP_BADCMD, 32'h0};
            ser_len  = 3'd1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_ADDR, ST_DATA: begin
        if (byte_acc) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (state_q == ST_ADDR) addr_d = ADDR_WIDTH'({addr_q, s_axis_tdata});
          else                    data_d = {data_q[23:0], s_axis_tdata};
          if (byte_cnt_q == 2'd3) begin
            if (state_q == ST_DATA) begin
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = ST_AW_W;
            end else if (is_write_q) begin
              state_d = ST_DATA;
            end else begin
              arvalid_d = 1'b1;
              state_d   = ST_AR;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          // Host went quiet mid-frame: drop it silently.
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_AW_W: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        // Leave as soon as both channels are done, including this cycle's handshakes.
        if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) state_d = ST_B;
      end
      ST_B: begin
        if (m_axil_bvalid && bready_q) begin
          ser_load = 1'b1;
          ser_data = {resp_status(m_axil_bresp), 32'h0};
          ser_len  = 3'd1;
          state_d  = ST_RESP;
        end
      end
      ST_AR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (m_axil_rvalid && rready_q) begin
          ser_load = 1'b1;
          ser_data = {resp_status(m_axil_rresp), m_axil_rdata};
          ser_len  = 3'd5;
          state_d  = ST_RESP;
        end
      end
      default: begin
        if (ser_done) state_d = ST_IDLE;
      end
    endcase
    s_tready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
    bready_d   = (state_d == ST_B);
    rready_d   = (state_d == ST_R);
  end

  // State and datapath registers; ready outputs are registered so they are low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      is_write_q <= 1'b0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      s_tready_q <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      s_tready_q <= s_tready_d;
      bready_q   <= bready_d;
      rready_q   <= rready_d;
    end
  end

endmodule
